// File: rtl/apb_pkg.sv
// Shared types for the APB requester.
// State encoding and default bus widths.
package apb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0]     wdata;
    logic [DATA_W_DEF/8-1:0]   strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase stall counter for the APB requester.
// expired is high in the cycle whose stall reaches the limit.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // count consecutive stalled ACCESS cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // limit reached on this stalled cycle
  always_comb begin
    expired = enable && (count == LIMIT);
  end

endmodule

// File: rtl/apb_master.sv
// APB4 requester: command/response handshake to one completer.
// Optional ACCESS timeout enabled by APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PERROR
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e state, state_nxt;
  logic       accept;
  logic       done;
  logic       abort;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  logic expired;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !PREADY),
    .expired (expired)
  );

  assign abort = expired;
`else
  assign abort = 1'b0;
`endif

  // state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and bus phase controls
  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (done || abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // latch command; reads carry no data or strobes
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_write ? cmd_wdata : '0;
      PSTRB  <= cmd_write ? cmd_strb : STRB_W'(0);
    end
  end

  // completion capture; fields hold until next completion
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done || abort;
      if (done) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_error   <= PERROR;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
